rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
- Parametrised integer register file for the pipelined core; successor to the single-write, two-read register file.
- Supports N read ports, M write-back ports with fixed priority, and correct same-cycle write-to-read bypass.
- Contains a per-register pending-write scoreboard, set at issue and cleared at write-back, which the hazard unit uses for stalls.
- Sits between decode (reads, issue) and write-back (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; higher index has higher priority.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses, packed; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  pending-write flag for each read address, combinational.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  an instruction writing iss_rd issues this cycle.
- iss_rd  in  AW  destination register of the issuing instruction.
- flush  in  1  pipeline flush; clears all pending flags.
- busy_vec  out  NREGS  full scoreboard state, for debug and hazard logic.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All registers become 0 and all busy bits become 0.
  - Outputs then reflect 0: rd_data = 0, rd_busy = 0, busy_vec = 0.
  - Reset asserted mid-operation aborts pending writes; nothing is written on that edge.
- Register 0 always reads 0 and is never busy.
  - Writes to address 0 are ignored.
  - Issue to address 0 is ignored.
  - A bypass from address 0 never occurs.
- Write:
  - The array updates at the rising edge when wr_en[j] is high and wr_addr[j] != 0.
  - If two ports target the same address in one cycle, the highest j wins and the others are dropped.
- Read: combinational.
  - Bypass rule: rd_data[k] equals wr_data of the highest-priority port j with wr_en[j]=1, wr_addr[j]=rd_addr[k] and rd_addr[k] != 0.
  - Otherwise rd_data[k] is the array content.
  - The bypass is qualified by wr_en; an address match alone never forwards.
  - Effective read-after-write latency: 0 cycles via bypass, array updated after 1 edge.
- Scoreboard: one busy bit per register.
  - Set: the busy bit for iss_rd sets at the edge when iss_en is high.
  - Clear: the busy bit for wr_addr[j] clears at the edge when wr_en[j] is high.
  - Set and clear on the same register in the same cycle: set wins (a newer producer exists).
  - flush clears all bits at the edge. flush has priority over iss_en in the same cycle.
  - Register writes still occur during flush.
- rd_busy[k]:
  - Equals busy_vec[rd_addr[k]], except it reads 0 when a write to rd_addr[k] is active this cycle, because the data is being bypassed.
  - Forced to 0 for address 0.
- No reset-synchroniser inside; rst_n is used directly as the asynchronous clear.

Optional Feature:
- Macro: RF_PARITY_EN.
- Defined:
  - Each register stores an even-parity bit, computed on write.
  - Extra output rd_perr (NRD bits): combinational, 1 when the stored parity mismatches the stored data.
  - rd_perr is 0 for bypassed reads and for address 0.
  - Parity bits reset to 0.
  - Extra input inj_perr (1 bit): when high, the parity stored on that edge's writes is inverted. It is a test hook only.
- Not defined: no parity storage, no rd_perr, no inj_perr ports.

Decomposition:
- Package rf_pkg holds:
  - RF_XLEN = 32, RF_NREGS = 32, RF_AW function (clog2 wrapper).
  - typedef rf_addr_t (logic [RF_AW-1:0]).
  - typedef rf_data_t (logic [RF_XLEN-1:0]).
- Sub-module rf_scoreboard: busy-bit array with set, clear and flush priority logic, parametrised by NREGS and NWR.
- The data array, write arbitration and bypass stay in rf_multiport.

Test Plan:
- Reset then read all addresses -> rd_data = 0, busy_vec = 0.
  - Write 0xDEADBEEF to x0 -> reading x0 returns 0.
- Write port0 x5 = 0x11, port1 x5 = 0x22 in the same cycle -> next cycle x5 = 0x22.
  - In the same cycle, a read of x5 returns 0x22 via bypass.
- iss_en with iss_rd = 7 -> busy_vec[7] = 1.
  - Later, wr_en with x7 = 0x33 and a concurrent read of x7 -> rd_data = 0x33, rd_busy = 0, busy_vec[7] = 0 after the edge.
- Same cycle: iss_rd = 9 and a write to x9 -> busy_vec[9] remains 1.
  - Then flush together with iss_en on x10 -> busy_vec = 0.
- Assert rst_n low between edges while x3 = 0x44 with a write pending -> x3 reads 0 immediately; no write occurs on the next edge.
- With RF_PARITY_EN: write x4 with inj_perr = 1 -> a subsequent read of x4 gives rd_perr = 1.
  - Rewrite x4 normally -> rd_perr = 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing constants and types for the multiport register file.
package rf_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;

    function automatic int unsigned RF_AW(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [RF_AW(RF_NREGS)-1:0] rf_addr_t;
    typedef logic [RF_XLEN-1:0]         rf_data_t;

endpackage

// File: rtl/rf_multiport_if.sv
// Decode/write-back bus of the register file. Parity signals exist only when
// RF_PARITY_EN is defined.
interface rf_multiport_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
);
    localparam int unsigned AW = RF_AW(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;
`ifdef RF_PARITY_EN
    logic                inj_perr;
    logic [NRD-1:0]      rd_perr;
`endif

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
`ifdef RF_PARITY_EN
        output inj_perr,
        input  rd_perr,
`endif
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd, flush,
`ifdef RF_PARITY_EN
        input  inj_perr,
        output rd_perr,
`endif
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: set on issue, cleared on write-back, flushed wholesale.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NWR   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         iss_en,
    input  logic [RF_AW(NREGS)-1:0]      iss_rd,
    input  logic                         flush,
    input  logic [NWR-1:0]               wr_en,
    input  logic [NWR*RF_AW(NREGS)-1:0]  wr_addr,
    output logic [NREGS-1:0]             busy_vec
);
    localparam int unsigned AW = RF_AW(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Ordering gives the priorities: issue overrides clear, flush overrides all.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (iss_en) busy_d[iss_rd] = 1'b1;
        if (flush)  busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_multiport.sv
// Multiport integer register file with write-to-read bypass and scoreboard.
// Optional stored parity with error reporting when RF_PARITY_EN is defined.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input logic           clk,
    input logic           rst_n,
    rf_multiport_if.slave bus
);
    localparam int unsigned AW = RF_AW(NREGS);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy_vec;
`ifdef RF_PARITY_EN
    logic [NREGS-1:0] par;
`endif

    // Ascending port order: the last assignment, from the highest port, wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
`ifdef RF_PARITY_EN
            par <= '0;
`endif
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0) begin
                    mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
`ifdef RF_PARITY_EN
                    par[bus.wr_addr[j*AW +: AW]] <= (^bus.wr_data[j*XLEN +: XLEN]) ^ bus.inj_perr;
`endif
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_rd   (bus.iss_rd),
        .flush    (bus.flush),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .busy_vec (busy_vec)
    );

    assign bus.busy_vec = busy_vec;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] byp;

        assign addr = bus.rd_addr[k*AW +: AW];

        // Writes are aborted while reset is held, so nothing is forwarded then.
        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (rst_n && bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == addr && addr != '0) begin
                    hit = 1'b1;
                    byp = bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? byp : mem[addr]);
        assign bus.rd_busy[k] = busy_vec[addr] & ~hit & (addr != '0);
`ifdef RF_PARITY_EN
        assign bus.rd_perr[k] = (addr != '0) & ~hit & ((^mem[addr]) ^ par[addr]);
`endif
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed and randomized check of rf_multiport against a register-level model.
// Parity checks are compiled in when RF_PARITY_EN is defined.
module tb_rf_multiport;
    import rf_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = RF_AW(NREGS);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_multiport_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    rf_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rf_data_t m_reg  [NREGS];
    bit       m_busy [NREGS];
    bit       m_pbad [NREGS];
    int       vectors     = 0;
    int       miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
            m_pbad[r] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.rd_addr = '0;
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.iss_en  = 1'b0;
        bus.iss_rd  = '0;
        bus.flush   = 1'b0;
`ifdef RF_PARITY_EN
        bus.inj_perr = 1'b0;
`endif
    endtask

    task automatic set_rd(input int k, input int a);
        bus.rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
        bus.wr_en[j]               = 1'b1;
        bus.wr_addr[j*AW +: AW]    = AW'(a);
        bus.wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int a);
        bus.iss_en = 1'b1;
        bus.iss_rd = AW'(a);
    endtask

    function automatic logic [NREGS-1:0] model_busy_vec();
        logic [NREGS-1:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // Expected combinational outputs: newest write to the address, else the stored value.
    task automatic check_reads();
        for (int k = 0; k < NRD; k++) begin
            int       a;
            bit       hit;
            rf_data_t ed;
            a   = int'(bus.rd_addr[k*AW +: AW]);
            hit = 1'b0;
            ed  = (a == 0 || !rst_n) ? '0 : m_reg[a];
            for (int j = NWR - 1; j >= 0; j--) begin
                if (!hit && rst_n && a != 0 && bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) begin
                    hit = 1'b1;
                    ed  = bus.wr_data[j*XLEN +: XLEN];
                end
            end
            chk($sformatf("rd_data%0d_x%0d", k, a), 64'(bus.rd_data[k*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("rd_busy%0d_x%0d", k, a), 64'(bus.rd_busy[k]),
                64'(rst_n && a != 0 && !hit && m_busy[a]));
`ifdef RF_PARITY_EN
            chk($sformatf("rd_perr%0d_x%0d", k, a), 64'(bus.rd_perr[k]),
                64'(rst_n && a != 0 && !hit && m_pbad[a]));
`endif
        end
        chk("busy_vec_comb", 64'(bus.busy_vec), 64'(model_busy_vec()));
    endtask

    task automatic peek();
        #1;
        check_reads();
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic tick();
        #1;
        check_reads();
        @(posedge clk);
        if (rst_n) begin
            for (int r = 1; r < NREGS; r++) begin
                bit written;
                bit issued;
                written = 1'b0;
                for (int j = NWR - 1; j >= 0; j--) begin
                    if (!written && bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == r) begin
                        written   = 1'b1;
                        m_reg[r]  = bus.wr_data[j*XLEN +: XLEN];
`ifdef RF_PARITY_EN
                        m_pbad[r] = bus.inj_perr;
`endif
                    end
                end
                issued = bus.iss_en && int'(bus.iss_rd) == r;
                if (bus.flush)  m_busy[r] = 1'b0;
                else if (issued) m_busy[r] = 1'b1;
                else if (written) m_busy[r] = 1'b0;
            end
        end
        #1;
        chk("busy_vec_edge", 64'(bus.busy_vec), 64'(model_busy_vec()));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();

        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a);
            set_rd(1, NREGS - 1 - a);
            peek();
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // x0 ignores writes
        idle(); set_wr(0, 0, 32'hDEADBEEF); set_rd(0, 0); tick();
        idle(); set_rd(0, 0); tick();
        chk("x0_reads_zero", 64'(bus.rd_data[0 +: XLEN]), 64'h0);

        // same-address write collision: port 1 wins, also on the bypass path
        idle(); set_wr(0, 5, 32'h11); set_wr(1, 5, 32'h22); set_rd(0, 5); set_rd(1, 5);
        #1;
        chk("x5_bypass", 64'(bus.rd_data[XLEN +: XLEN]), 64'h22);
        tick();
        idle(); set_rd(0, 5); tick();
        chk("x5_stored", 64'(bus.rd_data[0 +: XLEN]), 64'h22);

        // issue then write-back with a concurrent read
        idle(); iss(7); tick();
        chk("busy7_set", 64'(bus.busy_vec[7]), 64'h1);
        idle(); set_rd(0, 7); tick();
        idle(); set_wr(0, 7, 32'h33); set_rd(0, 7);
        #1;
        chk("x7_bypass", 64'(bus.rd_data[0 +: XLEN]), 64'h33);
        chk("x7_busy_masked", 64'(bus.rd_busy[0]), 64'h0);
        tick();
        chk("busy7_clear", 64'(bus.busy_vec[7]), 64'h0);

        // set beats clear; flush beats issue
        idle(); iss(9); set_wr(1, 9, 32'h99); tick();
        chk("busy9_kept", 64'(bus.busy_vec[9]), 64'h1);
        idle(); iss(12); tick();
        idle(); bus.flush = 1'b1; iss(10); tick();
        chk("flush_all", 64'(bus.busy_vec), 64'h0);

        // reset between edges aborts a pending write
        idle(); set_wr(0, 3, 32'h44); tick();
        idle(); set_wr(0, 3, 32'h55); set_rd(0, 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        peek();
        chk("x3_in_reset", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
        @(posedge clk);
        #2;
        idle(); set_rd(0, 3);
        rst_n = 1'b1;
        peek();
        chk("x3_after_reset", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
        tick();

`ifdef RF_PARITY_EN
        idle(); set_wr(0, 4, 32'h5A); bus.inj_perr = 1'b1; tick();
        idle(); set_rd(0, 4); tick();
        chk("x4_perr_injected", 64'(bus.rd_perr[0]), 64'h1);
        idle(); set_wr(1, 4, 32'h5A); tick();
        idle(); set_rd(0, 4); tick();
        chk("x4_perr_clean", 64'(bus.rd_perr[0]), 64'h0);
`endif

        // randomized traffic, mostly on a few registers to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int k = 0; k < NRD; k++)
                set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7),
                           XLEN'($urandom));
            if ($urandom_range(0, 2) == 0) iss($urandom_range(0, 7));
            bus.flush = ($urandom_range(0, 15) == 0);
`ifdef RF_PARITY_EN
            bus.inj_perr = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end

        idle();
        for (int a = 0; a < NREGS; a += 2) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            peek();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
